riscv_timer: RTL and testbench

//  Memory-mapped 64-bit machine timer on the core's data bus (dbus). Decodes a fixed address window.

---
 rtl/riscv_timer.sv | 191 +++++++++++++++++++
 tb/tb_riscv_timer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler on the core dbus.
// Optional TIMER_HI_LATCH_EN: MTIME_LO reads snapshot mtime[63:32] so LO-then-HI reads are atomic.
module riscv_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_data,
    input  logic [3:0]  I_mask,
    output logic [31:0] O_data,
    output logic        O_ready,
    output logic        O_timer_int
);

    localparam logic [2:0] SEL_CTRL     = 3'd0;
    localparam logic [2:0] SEL_MTIME_LO = 3'd1;
    localparam logic [2:0] SEL_MTIME_HI = 3'd2;
    localparam logic [2:0] SEL_CMP_LO   = 3'd3;
    localparam logic [2:0] SEL_CMP_HI   = 3'd4;

    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  mask
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic                  en_q,       en_d;
    logic [PRESCALE_W-1:0] div_q,      div_d;
    logic [PRESCALE_W-1:0] cnt_q,      cnt_d;
    logic [63:0]           mtime_q,    mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  ready_q,    ready_d;
    logic [31:0]           rdata_q,    rdata_d;
    logic                  int_q,      int_d;
`ifdef TIMER_HI_LATCH_EN
    logic [31:0]           shadow_q,   shadow_d;
`endif

    logic        in_window;
    logic        accept;
    logic        do_write;
    logic        do_read;
    logic [2:0]  sel;
    logic        wr_ctrl;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        tick;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_new;
    logic [31:0] read_mux;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^I_addr[1:0];

    // Address decode and single-outstanding handshake: nothing is accepted while ready is high.
    always_comb begin
        in_window   = (I_addr[31:5] == BASE_ADDR[31:5]);
        accept      = I_req && in_window && !ready_q;
        do_write    = accept && I_we && (I_mask != 4'b0000);
        do_read     = accept && !I_we;
        sel         = I_addr[4:2];
        wr_ctrl     = do_write && (sel == SEL_CTRL);
        wr_mtime_lo = do_write && (sel == SEL_MTIME_LO);
        wr_mtime_hi = do_write && (sel == SEL_MTIME_HI);
        wr_cmp_lo   = do_write && (sel == SEL_CMP_LO);
        wr_cmp_hi   = do_write && (sel == SEL_CMP_HI);
    end

    always_comb begin
        ctrl_word                   = 32'd0;
        ctrl_word[0]                = en_q;
        ctrl_word[8 +: PRESCALE_W]  = div_q;
        ctrl_new                    = merge_bytes(ctrl_word, I_data, I_mask);
    end

    // Prescaler: cnt walks 0..DIV, and the wrap cycle is the mtime tick.
    always_comb begin
        tick  = en_q && (cnt_q == div_q);
        en_d  = en_q;
        div_d = div_q;
        if (wr_ctrl) begin
            en_d  = ctrl_new[0];
            div_d = ctrl_new[8 +: PRESCALE_W];
        end

        cnt_d = cnt_q + CNT_ONE;
        if (wr_ctrl || !en_q || tick) begin
            cnt_d = '0;
        end
    end

    // A bus write to either mtime half overrides the tick, so no carry crosses into the other half.
    always_comb begin
        mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], I_data, I_mask)};
        end else if (wr_mtime_hi) begin
            mtime_d = {merge_bytes(mtime_q[63:32], I_data, I_mask), mtime_q[31:0]};
        end

        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo) begin
            mtimecmp_d = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], I_data, I_mask)};
        end else if (wr_cmp_hi) begin
            mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], I_data, I_mask), mtimecmp_q[31:0]};
        end

        int_d = (mtime_q >= mtimecmp_q);
    end

    always_comb begin
        case (sel)
            SEL_CTRL:     read_mux = ctrl_word;
            SEL_MTIME_LO: read_mux = mtime_q[31:0];
`ifdef TIMER_HI_LATCH_EN
            SEL_MTIME_HI: read_mux = shadow_q;
`else
            SEL_MTIME_HI: read_mux = mtime_q[63:32];
`endif
            SEL_CMP_LO:   read_mux = mtimecmp_q[31:0];
            SEL_CMP_HI:   read_mux = mtimecmp_q[63:32];
            default:      read_mux = 32'd0;
        endcase

        ready_d = accept;
        rdata_d = do_read ? read_mux : 32'd0;
    end

`ifdef TIMER_HI_LATCH_EN
    always_comb begin
        shadow_d = shadow_q;
        if (do_read && (sel == SEL_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            int_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            int_q      <= int_d;
        end
    end

`ifdef TIMER_HI_LATCH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 32'd0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    assign O_data      = rdata_q;
    assign O_ready     = ready_q;
    assign O_timer_int = int_q;

endmodule

// File: tb/tb_riscv_timer.sv
// Directed self-checking bench for riscv_timer: bus handshake, prescaler, compare, wrap,
// byte masking, window decode, write/tick collision, HI latch and reset mid-access.
module tb_riscv_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_req = 1'b0;
    logic        I_we = 1'b0;
    logic [31:0] I_addr = 32'd0;
    logic [31:0] I_data = 32'd0;
    logic [3:0]  I_mask = 4'd0;
    logic [31:0] O_data;
    logic        O_ready;
    logic        O_timer_int;

    int checkCount = 0;
    int errorCount = 0;

    riscv_timer dut (
        .clk         (clk),
        .rst         (rst),
        .I_req       (I_req),
        .I_we        (I_we),
        .I_addr      (I_addr),
        .I_data      (I_data),
        .I_mask      (I_mask),
        .O_data      (O_data),
        .O_ready     (O_ready),
        .O_timer_int (O_timer_int)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One bus access: drive on a negedge, accept on the next posedge, ready for exactly one cycle.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] mask, output logic [31:0] rdata);
        @(negedge clk);
        I_req  = 1'b1;
        I_we   = we;
        I_addr = addr;
        I_data = data;
        I_mask = mask;
        @(negedge clk);
        checkOutput("ready_after_accept", {31'd0, O_ready}, 32'd1);
        rdata  = O_data;
        I_req  = 1'b0;
        I_we   = 1'b0;
        I_mask = 4'd0;
        @(negedge clk);
        checkOutput("ready_one_cycle", {31'd0, O_ready}, 32'd0);
    endtask

    task automatic writeReg(input logic [31:0] offset, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] dummy;
        applyStimulus(1'b1, BASE + offset, data, mask, dummy);
    endtask

    task automatic readCheck(input string tag, input logic [31:0] offset, input logic [31:0] expected);
        logic [31:0] rd;
        applyStimulus(1'b0, BASE + offset, 32'd0, 4'd0, rd);
        checkOutput(tag, rd, expected);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int riseCycle;
        logic [31:0] expHi;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {31'd0, O_ready}, 32'd0);
        checkOutput("reset_data", O_data, 32'd0);
        checkOutput("reset_int", {31'd0, O_timer_int}, 32'd0);
        rst = 1'b0;

        readCheck("rst_ctrl", 32'h00, 32'd0);
        readCheck("rst_mtime_lo", 32'h04, 32'd0);
        readCheck("rst_cmp_hi", 32'h10, 32'hFFFF_FFFF);
        readCheck("rst_cmp_lo", 32'h0C, 32'hFFFF_FFFF);
        checkOutput("rst_int_idle", {31'd0, O_timer_int}, 32'd0);

        // Prescaler DIV=3: ticks land 4, 8, 12... edges after the CTRL write accept
        writeReg(32'h00, 32'h0000_0301, 4'hF);
        repeat (40) @(negedge clk);
        readCheck("div3_mtime_a", 32'h04, 32'd10);
        readCheck("div3_mtime_b", 32'h04, 32'd11);
        readCheck("div3_ctrl", 32'h00, 32'h0000_0301);
        @(negedge clk);
        writeReg(32'h00, 32'h0000_0000, 4'hF);
        readCheck("frozen_mtime", 32'h04, 32'd13);
        readCheck("frozen_mtime_again", 32'h04, 32'd13);

        // Byte masking, mask=0, reserved slots, low address bits, out-of-window
        writeReg(32'h04, 32'h0000_0000, 4'hF);
        writeReg(32'h08, 32'h0000_0000, 4'hF);
        writeReg(32'h04, 32'hAABB_CCDD, 4'b0010);
        readCheck("mask_lane1", 32'h04, 32'h0000_CC00);
        writeReg(32'h04, 32'hFFFF_FFFF, 4'b0000);
        readCheck("mask_zero", 32'h04, 32'h0000_CC00);
        writeReg(32'h18, 32'h1234_5678, 4'hF);
        readCheck("reserved_read", 32'h18, 32'd0);
        readCheck("addr_low_bits", 32'h0F, 32'hFFFF_FFFF);
        readCheck("mtime_hi_zero", 32'h08, 32'd0);

        @(negedge clk);
        I_req  = 1'b1;
        I_we   = 1'b1;
        I_addr = BASE + 32'h44;
        I_data = 32'hFFFF_FFFF;
        I_mask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("out_of_window_ready", {31'd0, O_ready}, 32'd0);
        end
        I_req  = 1'b0;
        I_we   = 1'b0;
        I_mask = 4'd0;
        readCheck("out_of_window_no_write", 32'h04, 32'h0000_CC00);

        // Compare: mtime counts from 0 at DIV=0, interrupt follows reaching 20 by one cycle
        writeReg(32'h04, 32'h0000_0000, 4'hF);
        writeReg(32'h10, 32'h0000_0000, 4'hF);
        writeReg(32'h0C, 32'd20, 4'hF);
        checkOutput("int_below_cmp", {31'd0, O_timer_int}, 32'd0);
        writeReg(32'h00, 32'h0000_0001, 4'hF);
        checkOutput("int_still_low", {31'd0, O_timer_int}, 32'd0);
        riseCycle = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (O_timer_int) begin
                riseCycle = i;
                break;
            end
        end
        checkOutput("int_rise_latency", riseCycle, 32'd20);
        writeReg(32'h0C, 32'hFFFF_FFFF, 4'hF);
        checkOutput("int_fall_after_cmp_raise", {31'd0, O_timer_int}, 32'd0);
        writeReg(32'h00, 32'h0000_0000, 4'hF);

        // 64-bit wrap: FFFF_FFFF_FFFF_FFFE plus two ticks is 0
        writeReg(32'h08, 32'hFFFF_FFFF, 4'hF);
        writeReg(32'h04, 32'hFFFF_FFFE, 4'hF);
        checkOutput("int_high_before_wrap", {31'd0, O_timer_int}, 32'd1);
        writeReg(32'h00, 32'h0000_0001, 4'hF);
        readCheck("wrap_lo", 32'h04, 32'd0);
        checkOutput("int_low_after_wrap", {31'd0, O_timer_int}, 32'd0);
        readCheck("wrap_hi", 32'h08, 32'd0);
        writeReg(32'h00, 32'h0000_0000, 4'hF);
        writeReg(32'h0C, 32'h0000_0000, 4'hF);
        checkOutput("int_cmp_zero", {31'd0, O_timer_int}, 32'd1);

        // HI latch: LO read just before the carry into HI
        writeReg(32'h08, 32'h0000_0001, 4'hF);
        writeReg(32'h04, 32'hFFFF_FFFD, 4'hF);
        writeReg(32'h00, 32'h0000_0001, 4'hF);
        readCheck("latch_lo", 32'h04, 32'hFFFF_FFFF);
`ifdef TIMER_HI_LATCH_EN
        expHi = 32'd1;
`else
        expHi = 32'd2;
`endif
        readCheck("latch_hi", 32'h08, expHi);

        // Write to LO while ticking: write value wins, then two more ticks before the read
        writeReg(32'h04, 32'h0000_0100, 4'hF);
        readCheck("collision_lo", 32'h04, 32'h0000_0102);
        readCheck("collision_hi", 32'h08, 32'd2);

        // Reset in the middle of an access drops ready and restores registers
        writeReg(32'h10, 32'h0000_0000, 4'hF);
        checkOutput("int_before_reset", {31'd0, O_timer_int}, 32'd1);
        @(negedge clk);
        I_req  = 1'b1;
        I_we   = 1'b0;
        I_addr = BASE + 32'h04;
        @(negedge clk);
        checkOutput("midreset_ready_pending", {31'd0, O_ready}, 32'd1);
        rst   = 1'b1;
        I_req = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ready_dropped", {31'd0, O_ready}, 32'd0);
        checkOutput("midreset_int", {31'd0, O_timer_int}, 32'd0);
        checkOutput("midreset_data", O_data, 32'd0);
        rst = 1'b0;
        readCheck("post_reset_mtime_lo", 32'h04, 32'd0);
        readCheck("post_reset_mtime_hi", 32'h08, 32'd0);
        readCheck("post_reset_ctrl", 32'h00, 32'd0);
        readCheck("post_reset_cmp_hi", 32'h10, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
